// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: opcode encodings and FSM state encodings.
package load_store_unit_pkg;

  localparam int unsigned OPCODE_W = 5;
  typedef logic [OPCODE_W-1:0] opcode_t;

  localparam opcode_t OP_ADD = 5'h00;
  localparam opcode_t OP_LD  = 5'h10;
  localparam opcode_t OP_STR = 5'h11;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_ACCESS = 2'd1,
    LSU_RESP   = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Request, response and memory-side signals of the load/store unit bundled as one interface.
interface load_store_unit_if
  import load_store_unit_pkg::*;
#(
  parameter int unsigned BITS_DATA = 32,
  parameter int unsigned BITS_ADDR = 16,
  parameter int unsigned TAG_BITS  = 4
);
  logic                 in_valid;
  logic                 in_ready;
  opcode_t              in_opcode;
  logic [BITS_DATA-1:0] in_addr;
  logic [BITS_DATA-1:0] in_wdata;
  logic [TAG_BITS-1:0]  in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [BITS_DATA-1:0] out_data;
  logic [TAG_BITS-1:0]  out_tag;
  logic                 out_S;
  logic                 out_Z;
  logic                 out_err;
  logic                 mem_en;
  logic                 mem_we;
  logic [BITS_ADDR-1:0] mem_addr;
  logic [BITS_DATA-1:0] mem_wdata;
  logic [BITS_DATA-1:0] mem_rdata;

  modport slave (
    input  in_valid, in_opcode, in_addr, in_wdata, in_tag, out_ready, mem_rdata,
    output in_ready, out_valid, out_data, out_tag, out_S, out_Z, out_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_opcode, in_addr, in_wdata, in_tag, out_ready, mem_rdata,
    input  in_ready, out_valid, out_data, out_tag, out_S, out_Z, out_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_wait_counter.sv
// Wait-state down-counter: loads WAIT_STATES at the start of an access and flags the last cycle.
module lsu_wait_counter #(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned CNT_W       = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic done,
  output logic one_left
);

  logic [CNT_W-1:0] count_r;

  // Count register; saturates at zero so an idle decrement is harmless
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= CNT_W'(WAIT_STATES);
    end else if (dec && (count_r != '0)) begin
      count_r <= count_r - CNT_W'(1);
    end
  end

  assign done     = (count_r == '0);
  assign one_left = (count_r == CNT_W'(1));

endmodule

// File: rtl/load_store_unit.sv
// Load/store memory stage: IDLE -> ACCESS -> RESP with one access in flight.
// Build option: define LSU_ALIGN_CHECK_EN to reject LD/STR with a non-word-aligned address.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned BITS_DATA   = 32,
  parameter int unsigned BITS_ADDR   = 16,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned TAG_BITS    = 4
) (
  input logic              clk,
  input logic              reset,
  load_store_unit_if.slave bus
);

  localparam int unsigned CNT_W     = (WAIT_STATES < 32'd1) ? 1 : $clog2(WAIT_STATES + 32'd1);
  localparam bit          ZERO_WAIT = (WAIT_STATES == 32'd0);

  lsu_state_t           state_r;
  logic                 in_ready_r;
  logic                 is_str_r;
  logic                 mem_en_r;
  logic                 mem_we_r;
  logic [BITS_ADDR-1:0] mem_addr_r;
  logic [BITS_DATA-1:0] mem_wdata_r;
  logic                 out_valid_r;
  logic                 out_err_r;
  logic [BITS_DATA-1:0] out_data_r;
  logic [TAG_BITS-1:0]  out_tag_r;
  logic                 out_s_r;
  logic                 out_z_r;

  logic                 hs_s;
  logic                 is_mem_op_s;
  logic                 is_str_s;
  logic                 misalign_s;
  logic                 access_ok_s;
  logic                 cnt_done_s;
  logic                 cnt_one_s;
  logic [BITS_DATA-1:0] resp_data_s;
  logic                 unused_s;

  assign hs_s        = bus.in_valid & bus.in_ready;
  assign resp_data_s = is_str_r ? mem_wdata_r : bus.mem_rdata;
  assign unused_s    = ^{bus.in_addr[BITS_DATA-1:BITS_ADDR+2], bus.in_addr[1:0]};

  // Opcode decode: only LD and STR reach memory
  always_comb begin
    is_mem_op_s = 1'b0;
    is_str_s    = 1'b0;
    case (bus.in_opcode)
      OP_LD: begin
        is_mem_op_s = 1'b1;
        is_str_s    = 1'b0;
      end
      OP_STR: begin
        is_mem_op_s = 1'b1;
        is_str_s    = 1'b1;
      end
      default: begin
        is_mem_op_s = 1'b0;
        is_str_s    = 1'b0;
      end
    endcase
  end

`ifdef LSU_ALIGN_CHECK_EN
  assign misalign_s = |bus.in_addr[1:0];
`else
  assign misalign_s = 1'b0;
`endif

  assign access_ok_s = is_mem_op_s & ~misalign_s;

  lsu_wait_counter #(
    .WAIT_STATES (WAIT_STATES),
    .CNT_W       (CNT_W)
  ) u_wait_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (hs_s & access_ok_s),
    .dec      (state_r == LSU_ACCESS),
    .done     (cnt_done_s),
    .one_left (cnt_one_s)
  );

  // Main FSM; every bus-facing output is a register written here
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= LSU_IDLE;
      in_ready_r  <= 1'b1;
      is_str_r    <= 1'b0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      out_valid_r <= 1'b0;
      out_err_r   <= 1'b0;
      out_data_r  <= '0;
      out_tag_r   <= '0;
      out_s_r     <= 1'b0;
      out_z_r     <= 1'b1;
    end else begin
      case (state_r)
        LSU_IDLE: begin
          if (hs_s) begin
            in_ready_r  <= 1'b0;
            is_str_r    <= is_str_s;
            out_tag_r   <= bus.in_tag;
            mem_addr_r  <= bus.in_addr[BITS_ADDR+1:2];
            mem_wdata_r <= bus.in_wdata;
            if (access_ok_s) begin
              state_r  <= LSU_ACCESS;
              mem_en_r <= 1'b1;
              mem_we_r <= is_str_s & ZERO_WAIT;
            end else begin
              // Rejected request: respond at once without touching memory
              state_r     <= LSU_RESP;
              out_valid_r <= 1'b1;
              out_err_r   <= 1'b1;
              out_data_r  <= '0;
              out_s_r     <= 1'b0;
              out_z_r     <= 1'b1;
            end
          end
        end
        LSU_ACCESS: begin
          if (cnt_done_s) begin
            state_r     <= LSU_RESP;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            out_valid_r <= 1'b1;
            out_err_r   <= 1'b0;
            out_data_r  <= resp_data_s;
            out_s_r     <= resp_data_s[BITS_DATA-1];
            out_z_r     <= ~|resp_data_s;
          end else begin
            // Write strobe lands on the final access cycle only
            mem_we_r <= is_str_r & cnt_one_s;
          end
        end
        LSU_RESP: begin
          if (bus.out_ready) begin
            state_r     <= LSU_IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= LSU_IDLE;
          in_ready_r  <= 1'b1;
          mem_en_r    <= 1'b0;
          mem_we_r    <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r & ~reset;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_tag   = out_tag_r;
  assign bus.out_S     = out_s_r;
  assign bus.out_Z     = out_z_r;
  assign bus.out_err   = out_err_r;
  assign bus.mem_en    = mem_en_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: one instance with WAIT_STATES=1, one with WAIT_STATES=0.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    logic        s;
    logic        z;
    logic        err;
    int          lat;
    int          en_cycles;
    int          we_cnt;
    int          we_off;
    logic [15:0] maddr;
    logic [31:0] mwdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q[$];

  logic        drv_valid = 1'b0;
  logic        drv_ready = 1'b1;
  opcode_t     drv_op    = OP_ADD;
  logic [31:0] drv_addr  = 32'h0;
  logic [31:0] drv_wdata = 32'h0;
  logic [31:0] drv_rdata = 32'h0;
  logic [3:0]  drv_tag   = 4'h0;
  logic        use_ws0   = 1'b0;

  load_store_unit_if b1 ();
  load_store_unit_if b0 ();

  load_store_unit #(.WAIT_STATES(1)) dut_ws1 (.clk(clk), .reset(rst), .bus(b1));
  load_store_unit #(.WAIT_STATES(0)) dut_ws0 (.clk(clk), .reset(rst), .bus(b0));

  assign b1.in_valid  = drv_valid & ~use_ws0;
  assign b0.in_valid  = drv_valid & use_ws0;
  assign b1.in_opcode = drv_op;
  assign b0.in_opcode = drv_op;
  assign b1.in_addr   = drv_addr;
  assign b0.in_addr   = drv_addr;
  assign b1.in_wdata  = drv_wdata;
  assign b0.in_wdata  = drv_wdata;
  assign b1.in_tag    = drv_tag;
  assign b0.in_tag    = drv_tag;
  assign b1.out_ready = drv_ready;
  assign b0.out_ready = drv_ready;
  assign b1.mem_rdata = drv_rdata;
  assign b0.mem_rdata = drv_rdata;

  // View of whichever instance is currently under test
  logic        m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_s, m_z, m_err, m_en, m_we;
  logic [31:0] m_data, m_wdata;
  logic [3:0]  m_tag;
  logic [15:0] m_addr;
  always_comb begin
    m_in_valid  = use_ws0 ? b0.in_valid  : b1.in_valid;
    m_in_ready  = use_ws0 ? b0.in_ready  : b1.in_ready;
    m_out_valid = use_ws0 ? b0.out_valid : b1.out_valid;
    m_out_ready = drv_ready;
    m_data      = use_ws0 ? b0.out_data  : b1.out_data;
    m_tag       = use_ws0 ? b0.out_tag   : b1.out_tag;
    m_s         = use_ws0 ? b0.out_S     : b1.out_S;
    m_z         = use_ws0 ? b0.out_Z     : b1.out_Z;
    m_err       = use_ws0 ? b0.out_err   : b1.out_err;
    m_en        = use_ws0 ? b0.mem_en    : b1.mem_en;
    m_we        = use_ws0 ? b0.mem_we    : b1.mem_we;
    m_addr      = use_ws0 ? b0.mem_addr  : b1.mem_addr;
    m_wdata     = use_ws0 ? b0.mem_wdata : b1.mem_wdata;
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: tracks memory activity per transaction and checks each response against the queue head
  int busy = 0, seen = 0, hs_cyc = 0, en_cnt = 0, we_cnt = 0, we_off = 0;
  always @(negedge clk) begin
    if (rst) begin
      busy = 0;
      seen = 0;
    end else begin
      if (busy != 0 && q.size() != 0) begin
        if (m_en) begin
          en_cnt = en_cnt + 1;
          chk("mem_addr", 32'(m_addr), 32'(q[0].maddr));
          chk("mem_wdata", m_wdata, q[0].mwdata);
        end
        if (m_we) begin
          we_cnt = we_cnt + 1;
          we_off = cyc - hs_cyc;
        end
      end
      if (m_out_valid) begin
        if (q.size() == 0) begin
          checks = checks + 1;
          errors = errors + 1;
          $display("FAIL spurious_out_valid: got 1 expected 0 (t=%0t)", $time);
        end else begin
          if (seen == 0) begin
            chk("latency", 32'(cyc - hs_cyc), 32'(q[0].lat));
            chk("mem_en_cycles", 32'(en_cnt), 32'(q[0].en_cycles));
            chk("mem_we_count", 32'(we_cnt), 32'(q[0].we_cnt));
            if (q[0].we_cnt != 0) chk("mem_we_cycle", 32'(we_off), 32'(q[0].we_off));
            seen = 1;
          end
          chk("out_data", m_data, q[0].data);
          chk("out_tag", 32'(m_tag), 32'(q[0].tag));
          chk("out_S", 32'(m_s), 32'(q[0].s));
          chk("out_Z", 32'(m_z), 32'(q[0].z));
          chk("out_err", 32'(m_err), 32'(q[0].err));
          chk("in_ready_in_resp", 32'(m_in_ready), 32'h0);
          if (m_out_ready) begin
            q.delete(0);
            busy = 0;
            seen = 0;
          end
        end
      end
      if (m_in_valid && m_in_ready) begin
        busy = 1;
        hs_cyc = cyc;
        en_cnt = 0;
        we_cnt = 0;
        we_off = 0;
        seen = 0;
      end
    end
  end

  task automatic start_txn(input logic ws0, input opcode_t op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata, input logic [3:0] tag,
                           input logic [31:0] exp_data, input logic es, input logic ez,
                           input logic eerr, input logic [15:0] maddr, input logic hold);
    exp_t e;
    int   ws;
    int   n;
    ws          = ws0 ? 0 : 1;
    e.data      = exp_data;
    e.tag       = tag;
    e.s         = es;
    e.z         = ez;
    e.err       = eerr;
    e.lat       = eerr ? 1 : ws + 2;
    e.en_cycles = eerr ? 0 : ws + 1;
    e.we_cnt    = (op == OP_STR && !eerr) ? 1 : 0;
    e.we_off    = ws + 1;
    e.maddr     = maddr;
    e.mwdata    = wdata;
    @(posedge clk);
    #1;
    use_ws0   = ws0;
    q.push_back(e);
    drv_op    = op;
    drv_addr  = addr;
    drv_wdata = wdata;
    drv_rdata = rdata;
    drv_tag   = tag;
    drv_ready = ~hold;
    drv_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n = n + 1;
    end while (!m_in_ready && n < 20);
    if (!m_in_ready) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    @(posedge clk);
    #1;
    drv_valid = 1'b0;
  endtask

  task automatic finish_txn(input int stall);
    int n;
    n = 0;
    while (!m_out_valid && n < 40) begin
      @(negedge clk);
      n = n + 1;
    end
    if (!m_out_valid) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL resp_timeout: out_valid got 0 expected 1");
    end else begin
      for (int i = 0; i < stall; i++) @(negedge clk);
      @(posedge clk);
      #1;
      drv_ready = 1'b1;
      n = 0;
      while (q.size() != 0 && n < 10) begin
        @(negedge clk);
        n = n + 1;
      end
      chk("resp_consumed", 32'(q.size()), 32'h0);
      @(negedge clk);
      chk("in_ready_after_resp", 32'(m_in_ready), 32'h1);
    end
  endtask

  task automatic run(input logic ws0, input opcode_t op, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rdata, input logic [3:0] tag,
                     input logic [31:0] exp_data, input logic es, input logic ez, input logic eerr,
                     input logic [15:0] maddr, input int stall);
    start_txn(ws0, op, addr, wdata, rdata, tag, exp_data, es, ez, eerr, maddr, stall != 0);
    finish_txn(stall);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(b1.in_ready), 32'h0);
    chk("rst_out_valid", 32'(b1.out_valid), 32'h0);
    chk("rst_mem_en", 32'(b1.mem_en), 32'h0);
    chk("rst_mem_we", 32'(b1.mem_we), 32'h0);
    chk("rst_out_data", b1.out_data, 32'h0);
    chk("rst_out_tag", 32'(b1.out_tag), 32'h0);
    chk("rst_mem_addr", 32'(b1.mem_addr), 32'h0);
    chk("rst_out_Z", 32'(b1.out_Z), 32'h1);
    chk("rst_ws0_out_valid", 32'(b0.out_valid), 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(b1.in_ready), 32'h1);
    chk("post_rst_ws0_in_ready", 32'(b0.in_ready), 32'h1);

    //   ws0   op      addr          wdata         rdata         tag    exp_data      S     Z     err   maddr     stall
    run(1'b0, OP_STR, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 4'd3,  32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 16'h0004, 0);
    run(1'b0, OP_LD,  32'h0000_0010, 32'hA5A5_A5A5, 32'h0000_0005, 4'd7,  32'h0000_0005, 1'b0, 1'b0, 1'b0, 16'h0004, 0);
    run(1'b0, OP_LD,  32'h0000_0020, 32'h0000_0000, 32'h0000_0000, 4'd1,  32'h0000_0000, 1'b0, 1'b1, 1'b0, 16'h0008, 0);
    run(1'b0, OP_LD,  32'h0000_0044, 32'h0000_0000, 32'h8000_0001, 4'd9,  32'h8000_0001, 1'b1, 1'b0, 1'b0, 16'h0011, 4);
    run(1'b0, OP_ADD, 32'h0000_0010, 32'h0000_1234, 32'hFFFF_FFFF, 4'd2,  32'h0000_0000, 1'b0, 1'b1, 1'b1, 16'h0004, 0);
    run(1'b0, OP_STR, 32'h0003_0008, 32'h0000_0100, 32'h0000_0000, 4'd12, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 16'hC002, 0);

    // Reset pulsed while an access is in flight: no response may follow
    start_txn(1'b0, OP_LD, 32'h0000_0040, 32'h0, 32'h0000_0042, 4'd8, 32'h0000_0042, 1'b0, 1'b0, 1'b0, 16'h0010, 1'b0);
    @(negedge clk);
    chk("abort_mem_en_before", 32'(m_en), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("abort_mem_en", 32'(m_en), 32'h0);
    chk("abort_mem_we", 32'(m_we), 32'h0);
    chk("abort_out_valid", 32'(m_out_valid), 32'h0);
    chk("abort_in_ready", 32'(m_in_ready), 32'h0);
    @(negedge clk);
    q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready_after", 32'(m_in_ready), 32'h1);
    repeat (4) @(negedge clk);
    chk("abort_no_response", 32'(m_out_valid), 32'h0);

`ifdef LSU_ALIGN_CHECK_EN
    run(1'b0, OP_LD, 32'h0000_0012, 32'h0, 32'h0000_0077, 4'd5, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 16'h0004, 0);
`else
    run(1'b0, OP_LD, 32'h0000_0012, 32'h0, 32'h0000_0077, 4'd5, 32'h0000_0077, 1'b0, 1'b0, 1'b0, 16'h0004, 0);
`endif

    run(1'b1, OP_LD,  32'h0000_0000, 32'h0000_0000, 32'h1234_5678, 4'd4,  32'h1234_5678, 1'b0, 1'b0, 1'b0, 16'h0000, 0);
    run(1'b1, OP_STR, 32'h0000_FFFC, 32'h0000_0000, 32'hFFFF_FFFF, 4'd15, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 16'h3FFF, 0);
    run(1'b1, OP_STR, 32'h0000_0008, 32'hFFFF_FFFF, 32'h0000_0000, 4'd6,  32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 16'h0002, 2);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
